// File: rtl/murmur_hash3_if.sv
// Key/seed request and digest response bundle for the murmur_hash3 engine.
interface murmur_hash3_if;
  logic        in_valid;
  logic [31:0] ip_int;
  logic [31:0] seed;
  logic        out_valid;
  logic [31:0] hash;

  modport master (
    output in_valid,
    output ip_int,
    output seed,
    input  out_valid,
    input  hash
  );

  modport slave (
    input  in_valid,
    input  ip_int,
    input  seed,
    output out_valid,
    output hash
  );
endinterface

// File: rtl/murmur_hash3.sv
// MurmurHash3_x86_32 of a single 4-byte key; one key per clock, no backpressure.
// Define MURMUR_HASH3_PIPELINE_EN for a 3-stage pipeline (latency 3); default latency is 1.
module murmur_hash3 (
  input  logic           clk,
  input  logic           rst,
  murmur_hash3_if.slave  bus_io
);

  localparam logic [31:0] C1     = 32'hCC9E2D51;
  localparam logic [31:0] C2     = 32'h1B873593;
  localparam logic [31:0] NAdd   = 32'hE6546B64;
  localparam logic [31:0] FMul1  = 32'h85EBCA6B;
  localparam logic [31:0] FMul2  = 32'hC2B2AE35;
  localparam logic [31:0] KeyLen = 32'd4;

  // Block mix plus the h*5+n step.
  function automatic logic [31:0] body_mix(input logic [31:0] key, input logic [31:0] sd);
    logic [31:0] k;
    logic [31:0] h;
    k = key * C1;
    k = {k[16:0], k[31:17]};
    k = k * C2;
    h = sd ^ k;
    h = {h[18:0], h[31:19]};
    h = h * 32'd5 + NAdd;
    return h;
  endfunction

  // Finalizer up to and including the first multiply.
  function automatic logic [31:0] fmix_a(input logic [31:0] hin);
    logic [31:0] h;
    h = hin ^ KeyLen;
    h = h ^ (h >> 16);
    h = h * FMul1;
    return h;
  endfunction

  function automatic logic [31:0] fmix_b(input logic [31:0] hin);
    logic [31:0] h;
    h = hin ^ (hin >> 13);
    h = h * FMul2;
    h = h ^ (h >> 16);
    return h;
  endfunction

  logic        out_valid_q, out_valid_d;
  logic [31:0] hash_q, hash_d;

`ifdef MURMUR_HASH3_PIPELINE_EN
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_h_q, s1_h_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_h_q, s2_h_d;

  always_comb begin
    s1_valid_d  = bus_io.in_valid;
    s1_h_d      = s1_h_q;
    s2_valid_d  = s1_valid_q;
    s2_h_d      = s2_h_q;
    out_valid_d = s2_valid_q;
    hash_d      = hash_q;
    if (bus_io.in_valid) s1_h_d = body_mix(bus_io.ip_int, bus_io.seed);
    if (s1_valid_q)      s2_h_d = fmix_a(s1_h_q);
    if (s2_valid_q)      hash_d = fmix_b(s2_h_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_h_q     <= 32'h0;
      s2_valid_q <= 1'b0;
      s2_h_q     <= 32'h0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_h_q     <= s1_h_d;
      s2_valid_q <= s2_valid_d;
      s2_h_q     <= s2_h_d;
    end
  end
`else
  always_comb begin
    out_valid_d = bus_io.in_valid;
    hash_d      = hash_q;
    if (bus_io.in_valid) begin
      hash_d = fmix_b(fmix_a(body_mix(bus_io.ip_int, bus_io.seed)));
    end
  end
`endif

  // hash only loads on a valid result so it holds across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      hash_q      <= 32'h0;
    end else begin
      out_valid_q <= out_valid_d;
      hash_q      <= hash_d;
    end
  end

  assign bus_io.out_valid = out_valid_q;
  assign bus_io.hash      = hash_q;

endmodule

// File: tb/tb_murmur_hash3.sv
// Directed and streaming checks of murmur_hash3 against known digests and a C-style model.
module tb_murmur_hash3;

`ifdef MURMUR_HASH3_PIPELINE_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  typedef struct {
    string       name;
    logic [31:0] ip;
    logic [31:0] sd;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  murmur_hash3_if bus_if ();

  murmur_hash3 dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_hold;
  int          seq_n;
  bit          seq_v  [64];
  logic [31:0] seq_ip [64];
  logic [31:0] seq_sd [64];

  // Reference written the way the C code reads: bytes, getblock, body, fmix32.
  function automatic logic [31:0] ref_hash(input logic [31:0] key, input logic [31:0] sd);
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] k1, h1;
    b0 = key[7:0]; b1 = key[15:8]; b2 = key[23:16]; b3 = key[31:24];
    k1 = {b3, b2, b1, b0};
    k1 = k1 * 32'hCC9E2D51;
    k1 = (k1 << 15) | (k1 >> 17);
    k1 = k1 * 32'h1B873593;
    h1 = sd ^ k1;
    h1 = (h1 << 13) | (h1 >> 19);
    h1 = h1 * 32'd5 + 32'hE6546B64;
    h1 = h1 ^ 32'd4;
    h1 = h1 ^ (h1 >> 16);
    h1 = h1 * 32'h85EBCA6B;
    h1 = h1 ^ (h1 >> 13);
    h1 = h1 * 32'hC2B2AE35;
    h1 = h1 ^ (h1 >> 16);
    return h1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    bus_if.in_valid = 1'b1;
    bus_if.ip_int   = v.ip;
    bus_if.seed     = v.sd;
    tick();
    bus_if.in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 10) begin
      if (bus_if.out_valid) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check({v.name, " latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(L));
    check({v.name, " hash"}, bus_if.hash, v.exp);
    exp_hold = v.exp;
    tick();
    check({v.name, " pulse"}, 32'(bus_if.out_valid), 32'd0);
    check({v.name, " hold"}, bus_if.hash, exp_hold);
  endtask

  // Drive seq_* on consecutive cycles; output for input j is due after its L-th edge.
  task automatic run_seq(input string nm);
    int j;
    for (int c = 0; c < seq_n + L + 1; c++) begin
      if (c < seq_n) begin
        bus_if.in_valid = seq_v[c];
        bus_if.ip_int   = seq_ip[c];
        bus_if.seed     = seq_sd[c];
      end else begin
        bus_if.in_valid = 1'b0;
      end
      tick();
      j = c - L + 1;
      if (j >= 0 && j < seq_n && seq_v[j]) begin
        exp_hold = ref_hash(seq_ip[j], seq_sd[j]);
        check($sformatf("%s[%0d] valid", nm, c), 32'(bus_if.out_valid), 32'd1);
      end else begin
        check($sformatf("%s[%0d] valid", nm, c), 32'(bus_if.out_valid), 32'd0);
      end
      check($sformatf("%s[%0d] hash", nm, c), bus_if.hash, exp_hold);
    end
  endtask

  initial begin
    vec_t vecs [6];
    int   pre_rst;

    vecs[0] = '{"kv87654321_s0",  32'h87654321, 32'h00000000, 32'hF55B516B};
    vecs[1] = '{"kv87654321_sed", 32'h87654321, 32'h5082EDEE, 32'h2362F9DE};
    vecs[2] = '{"kv0_s0",         32'h00000000, 32'h00000000, 32'h2362F9DE};
    vecs[3] = '{"kvffffffff_s0",  32'hFFFFFFFF, 32'h00000000, 32'h76293B50};
    vecs[4] = '{"kv_aaaa",        32'h61616161, 32'h9747B28C, 32'h5A97808A};
    vecs[5] = '{"kv_abcd",        32'h64636261, 32'h9747B28C, 32'hF0478627};

    rst             = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.ip_int   = 32'h0;
    bus_if.seed     = 32'h0;
    tick();
    tick();
    check("reset out_valid", 32'(bus_if.out_valid), 32'd0);
    check("reset hash", bus_if.hash, 32'h0);
    rst      = 1'b0;
    exp_hold = 32'h0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Four back-to-back addresses.
    seq_n = 4;
    seq_ip[0] = 32'hC0A80101; seq_ip[1] = 32'h0A000001;
    seq_ip[2] = 32'hAC100001; seq_ip[3] = 32'h7F000001;
    for (int i = 0; i < 4; i++) begin
      seq_v[i]  = 1'b1;
      seq_sd[i] = 32'h12345678;
    end
    run_seq("stream");

    // Bubble pattern 1,0,1,1,0.
    seq_n = 5;
    seq_v[0] = 1'b1; seq_v[1] = 1'b0; seq_v[2] = 1'b1; seq_v[3] = 1'b1; seq_v[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seq_ip[i] = 32'h0A0A0000 + 32'(i);
      seq_sd[i] = 32'hDEADBEEF;
    end
    run_seq("bubble");

    // Reset one edge after two keys; the rst edge also carries a key that must be dropped.
    pre_rst = 0;
    bus_if.in_valid = 1'b1; bus_if.ip_int = 32'h01020304; bus_if.seed = 32'h0;
    tick();
    if (bus_if.out_valid) pre_rst++;
    bus_if.ip_int = 32'h05060708;
    tick();
    if (bus_if.out_valid) pre_rst++;
    rst           = 1'b1;
    bus_if.ip_int = 32'h090A0B0C;
    tick();
    check("rst outputs before rst", 32'(pre_rst), (L == 1) ? 32'd2 : 32'd0);
    check("rst out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst hash", bus_if.hash, 32'h0);
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    for (int c = 0; c < L + 2; c++) begin
      tick();
      check($sformatf("post rst[%0d] valid", c), 32'(bus_if.out_valid), 32'd0);
      check($sformatf("post rst[%0d] hash", c), bus_if.hash, 32'h0);
    end
    exp_hold = 32'h0;

    // Random mix of valid/idle cycles.
    seq_n = 64;
    for (int i = 0; i < 64; i++) begin
      seq_v[i]  = ($urandom_range(0, 3) != 0);
      seq_ip[i] = $urandom;
      seq_sd[i] = $urandom;
    end
    run_seq("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
